// File: rtl/dp_pkg.sv
// Shared types for the sequenced datapath: command encodings, sequencer
// states, the latched-command record and the status flag bit positions.
package dp_pkg;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    VSEL_C      = 2'b00,
    VSEL_MDATA  = 2'b01,
    VSEL_SXIMM8 = 2'b10,
    VSEL_PC     = 2'b11
  } vsel_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LDA  = 3'd1,
    ST_LDB  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } dp_state_e;

  // Control part of a command, captured on the accepting edge.
  typedef struct packed {
    alu_op_e alu_op;
    shift_e  shift;
    vsel_e   vsel;
    logic    asel;
    logic    bsel;
    logic    wb;
    logic    setflags;
  } dp_cmd_t;

  // Bit positions inside the {V, N, Z} status vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/regfile_rst.sv
// Register file with one write port, two combinational read ports and a
// synchronous reset that clears every entry.
module regfile_rst #(
  parameter  int W    = 16,
  parameter  int NREG = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [RW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [RW-1:0] raddr_a_i,
  input  logic [RW-1:0] raddr_b_i,
  output logic [W-1:0]  rdata_a_o,
  output logic [W-1:0]  rdata_b_o
);

  logic [W-1:0] regs_q [NREG];

  // Storage update: reset clears all entries and takes priority over a write.
  // NOTE: the whole array is reset on purpose (software relies on zeroed
  // registers); this rules out a plain RAM macro, so keep NREG small.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/datapath_seq.sv
// Datapath with a built-in micro-sequencer: one start pulse runs
// read-A / read-B / execute / write-back and ends with a done pulse.
// Immediate-style writes (vsel != C) skip straight to write-back.
module datapath_seq
  import dp_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int NREG = 8,
  parameter  int PCW  = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [RW-1:0] rnA,
  input  logic [RW-1:0] rnB,
  input  logic [RW-1:0] writenum,
  input  logic          wb,
  input  logic          setflags,
  input  logic [1:0]    ALUop,
  input  logic [1:0]    shift,
  input  logic [1:0]    vsel,
  input  logic          asel,
  input  logic          bsel,
  input  logic [W-1:0]  mdata,
  input  logic [W-1:0]  sximm8,
  input  logic [W-1:0]  sximm5,
  input  logic [PCW-1:0] PC,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  datapath_out,
  output logic [2:0]    status
);

  dp_state_e     state_q;
  logic          busy_q, done_q;
  dp_cmd_t       cmd_q;
  logic [RW-1:0] rna_q, rnb_q, wn_q;
  logic [W-1:0]  mdata_q, sximm8_q, sximm5_q;
  logic [PCW-1:0] pc_q;
  logic [W-1:0]  a_q, b_q, c_q;
  logic [2:0]    status_q;

  logic [W-1:0]  rd_a, rd_b;
  logic [W-1:0]  b_shifted, ain, bin, c_d;
  logic [2:0]    status_d;
  logic [W-1:0]  pc_ext, wdata;
  logic          rf_we;
  logic          accept;

  assign accept = start && (state_q == ST_IDLE);

  // Sequencer: walks the operation states and registers busy/done.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= (vsel_e'(vsel) == VSEL_C) ? ST_LDA : ST_WB;
            busy_q  <= 1'b1;
          end
        end
        ST_LDA:  state_q <= ST_LDB;
        ST_LDB:  state_q <= ST_EXEC;
        ST_EXEC: state_q <= ST_WB;
        ST_WB: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Command latch: every command input is captured on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q    <= '0;
      rna_q    <= '0;
      rnb_q    <= '0;
      wn_q     <= '0;
      mdata_q  <= '0;
      sximm8_q <= '0;
      sximm5_q <= '0;
      pc_q     <= '0;
    end else if (accept) begin
      cmd_q.alu_op   <= alu_op_e'(ALUop);
      cmd_q.shift    <= shift_e'(shift);
      cmd_q.vsel     <= vsel_e'(vsel);
      cmd_q.asel     <= asel;
      cmd_q.bsel     <= bsel;
      cmd_q.wb       <= wb;
      cmd_q.setflags <= setflags;
      rna_q          <= rnA;
      rnb_q          <= rnB;
      wn_q           <= writenum;
      mdata_q        <= mdata;
      sximm8_q       <= sximm8;
      sximm5_q       <= sximm5;
      pc_q           <= PC;
    end
  end

  // Shifter, operand muxes and ALU with flag generation.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    b_shifted = b_q;
    c_d       = '0;
    status_d  = '0;
    case (cmd_q.shift)
      SH_LSL:  b_shifted = {b_q[W-2:0], 1'b0};
      SH_LSR:  b_shifted = {1'b0, b_q[W-1:1]};
      SH_ASR:  b_shifted = {b_q[W-1], b_q[W-1:1]};
      default: b_shifted = b_q;
    endcase
    ain = cmd_q.asel ? '0 : a_q;
    bin = cmd_q.bsel ? sximm5_q : b_shifted;
    case (cmd_q.alu_op)
      ALU_ADD: begin
        c_d = ain + bin;
        status_d[FLAG_V] = (ain[W-1] == bin[W-1]) && (c_d[W-1] != ain[W-1]);
      end
      ALU_SUB: begin
        c_d = ain - bin;
        status_d[FLAG_V] = (ain[W-1] != bin[W-1]) && (c_d[W-1] != ain[W-1]);
      end
      ALU_AND: c_d = ain & bin;
      default: c_d = ~bin;
    endcase
    status_d[FLAG_Z] = (c_d == '0);
    status_d[FLAG_N] = c_d[W-1];
  end

  // Operand and result registers: A in LDA, B in LDB, C/status in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      case (state_q)
        ST_LDA: a_q <= rd_a;
        ST_LDB: b_q <= rd_b;
        ST_EXEC: begin
          c_q <= c_d;
          if (cmd_q.setflags) status_q <= status_d;
        end
        default: ;
      endcase
    end
  end

  // Write-back source selection; PC is zero-extended to the data width.
  always_comb begin
    pc_ext = '0;
    pc_ext[PCW-1:0] = pc_q;
    case (cmd_q.vsel)
      VSEL_MDATA:  wdata = mdata_q;
      VSEL_SXIMM8: wdata = sximm8_q;
      VSEL_PC:     wdata = pc_ext;
      default:     wdata = c_q;
    endcase
  end

  // Reset inside the register file wins over this enable, so an in-flight
  // write-back is dropped when reset lands in WB.
  assign rf_we = (state_q == ST_WB) && cmd_q.wb;

  regfile_rst #(.W(W), .NREG(NREG)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (rf_we),
    .waddr_i   (wn_q),
    .wdata_i   (wdata),
    .raddr_a_i (rna_q),
    .raddr_b_i (rnb_q),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign datapath_out = c_q;
  assign status       = status_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: expected results are queued when a
// command is issued and compared when its done pulse appears. Two extra
// instances cover the narrow and wide parameter sets.
module tb_datapath_seq;

  logic        clk = 1'b0;
  logic        reset, start, start8, start32;
  logic [3:0]  rna_b, rnb_b, wn_b;
  logic        wb_b, sf_b, asel_b, bsel_b;
  logic [1:0]  op_b, sh_b, vs_b;
  logic [31:0] md_b, s8_b, s5_b;
  logic [7:0]  pc_b;

  logic        busy, done;
  logic [15:0] dout;
  logic [2:0]  status;
  logic        busy8, done8;
  logic [7:0]  dout8;
  logic [2:0]  status8;
  logic        busy32, done32;
  logic [31:0] dout32;
  logic [2:0]  status32;

  always #5 clk = ~clk;

  datapath_seq #(.W(16), .NREG(8), .PCW(8)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .rnA(rna_b[2:0]), .rnB(rnb_b[2:0]), .writenum(wn_b[2:0]),
    .wb(wb_b), .setflags(sf_b), .ALUop(op_b), .shift(sh_b), .vsel(vs_b),
    .asel(asel_b), .bsel(bsel_b),
    .mdata(md_b[15:0]), .sximm8(s8_b[15:0]), .sximm5(s5_b[15:0]), .PC(pc_b),
    .busy(busy), .done(done), .datapath_out(dout), .status(status)
  );

  datapath_seq #(.W(8), .NREG(4), .PCW(4)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .rnA(rna_b[1:0]), .rnB(rnb_b[1:0]), .writenum(wn_b[1:0]),
    .wb(wb_b), .setflags(sf_b), .ALUop(op_b), .shift(sh_b), .vsel(vs_b),
    .asel(asel_b), .bsel(bsel_b),
    .mdata(md_b[7:0]), .sximm8(s8_b[7:0]), .sximm5(s5_b[7:0]), .PC(pc_b[3:0]),
    .busy(busy8), .done(done8), .datapath_out(dout8), .status(status8)
  );

  datapath_seq #(.W(32), .NREG(16), .PCW(8)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32),
    .rnA(rna_b), .rnB(rnb_b), .writenum(wn_b),
    .wb(wb_b), .setflags(sf_b), .ALUop(op_b), .shift(sh_b), .vsel(vs_b),
    .asel(asel_b), .bsel(bsel_b),
    .mdata(md_b), .sximm8(s8_b), .sximm5(s5_b), .PC(pc_b),
    .busy(busy32), .done(done32), .datapath_out(dout32), .status(status32)
  );

  typedef struct {
    logic [31:0] dout;
    logic [2:0]  st;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_dout_m;
  logic [2:0]  exp_st_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Randomise every command input so later changes prove the latch works.
  task automatic scramble();
    start   = 1'b0;
    start8  = 1'b0;
    start32 = 1'b0;
    rna_b   = 4'($urandom);
    rnb_b   = 4'($urandom);
    wn_b    = 4'($urandom);
    wb_b    = 1'($urandom);
    sf_b    = 1'($urandom);
    asel_b  = 1'($urandom);
    bsel_b  = 1'($urandom);
    op_b    = 2'($urandom);
    sh_b    = 2'($urandom);
    vs_b    = 2'($urandom);
    md_b    = $urandom;
    s8_b    = $urandom;
    s5_b    = $urandom;
    pc_b    = 8'($urandom);
  endtask

  // Present a command for one cycle on the default instance.
  task automatic drive(input logic [3:0] ra, rb, wn, input logic w, f,
                       input logic [1:0] op, sh, vs, input logic as, bs,
                       input logic [31:0] md, s8, s5, input logic [7:0] pc);
    rna_b = ra; rnb_b = rb; wn_b = wn; wb_b = w; sf_b = f;
    op_b = op; sh_b = sh; vs_b = vs; asel_b = as; bsel_b = bs;
    md_b = md; s8_b = s8; s5_b = s5; pc_b = pc;
    start = 1'b1;
    step();
    scramble();
  endtask

  task automatic issue(input logic [3:0] ra, rb, wn, input logic w, f,
                       input logic [1:0] op, sh, vs, input logic as, bs,
                       input logic [31:0] md, s8, s5, input logic [7:0] pc,
                       input logic [31:0] e_dout, input logic [2:0] e_st);
    exp_t e;
    e.dout = e_dout;
    e.st   = e_st;
    e.lat  = (vs == 2'b00) ? 5 : 2;
    sb_q.push_back(e);
    exp_dout_m = e_dout;
    exp_st_m   = e_st;
    drive(ra, rb, wn, w, f, op, sh, vs, as, bs, md, s8, s5, pc);
  endtask

  // Returns at the falling edge of the done cycle, then checks the
  // oldest queued expectation against the measured latency and outputs.
  task automatic wait_done(input int elapsed);
    exp_t e;
    int   lat;
    bit   got;
    lat = elapsed;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
      end else begin
        check("busy_running", 32'(busy), 32'd1);
        step();
        lat++;
      end
    end
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else begin e.dout = '0; e.st = '0; e.lat = 0; end
    check("latency", 32'(lat), 32'(e.lat));
    check("busy_at_done", 32'(busy), 32'd0);
    check("datapath_out", 32'(dout), e.dout);
    check("status", 32'(status), 32'(e.st));
  endtask

  task automatic imm_write(input logic [3:0] r, input logic [31:0] v);
    issue(r, 4'd0, r, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0,
          32'd0, v, 32'd0, 8'd0, exp_dout_m, exp_st_m);
    wait_done(1);
    step();
  endtask

  task automatic alu(input logic [3:0] ra, rb, wn, input logic w, f,
                     input logic [1:0] op, sh, input logic as, bs,
                     input logic [31:0] s5, input logic [31:0] e_dout,
                     input logic [2:0] e_st);
    issue(ra, rb, wn, w, f, op, sh, 2'b00, as, bs, 32'd0, 32'd0, s5, 8'd0,
          e_dout, e_st);
    wait_done(1);
    step();
  endtask

  // Read a register by routing it through the ALU: C = reg[r] + 0.
  task automatic read_reg(input logic [3:0] r, input logic [31:0] v);
    alu(r, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 32'd0, v, exp_st_m);
  endtask

  initial begin
    int extra;
    scramble();
    reset = 1'b1;
    exp_dout_m = '0;
    exp_st_m   = '0;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_status", 32'(status), 32'd0);

    // Immediate writes then R2 = R0 + (R1 << 1).
    imm_write(4'd0, 32'h0007);
    imm_write(4'd1, 32'h0002);
    alu(4'd0, 4'd1, 4'd2, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 32'd0, 32'h000B, 3'b000);
    read_reg(4'd2, 32'h000B);

    // Signed overflow on subtract, then zero result.
    imm_write(4'd3, 32'h7FFF);
    imm_write(4'd4, 32'hFFFF);
    alu(4'd3, 4'd4, 4'd5, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 32'd0, 32'h8000, 3'b110);
    alu(4'd3, 4'd3, 4'd3, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 32'd0, 32'h0000, 3'b001);

    // NOT of arithmetic-right-shifted B; flags untouched without setflags.
    imm_write(4'd6, 32'h8004);
    alu(4'd0, 4'd6, 4'd0, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 32'd0, 32'h3FFD, 3'b001);
    // A forced to zero, B from sximm5 with the shifter bypassed.
    alu(4'd5, 4'd6, 4'd0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 1'b1, 32'hFFF0, 32'hFFF0, 3'b010);

    // wb=0 left R3 alone; R5 holds the earlier subtract result.
    read_reg(4'd3, 32'h7FFF);
    read_reg(4'd5, 32'h8000);

    // mdata into the top register, PC (zero-extended) into R1.
    issue(4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0,
          32'h1357, 32'd0, 32'd0, 8'd0, exp_dout_m, exp_st_m);
    wait_done(1);
    step();
    read_reg(4'd7, 32'h1357);
    issue(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0,
          32'd0, 32'd0, 32'd0, 8'hC3, exp_dout_m, exp_st_m);
    wait_done(1);
    step();
    read_reg(4'd1, 32'h00C3);

    // start in cycle 2 of a running command is dropped.
    issue(4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1,
          32'd0, 32'd0, 32'd0, 8'd0, 32'h000B, exp_st_m);
    step();
    vs_b = 2'b10; wn_b = 4'd6; wb_b = 1'b1; s8_b = 32'hDEAD;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(3);
    extra = 0;
    repeat (6) begin
      step();
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("ignored_start", 32'(extra), 32'd0);
    step();
    read_reg(4'd6, 32'h8004);

    // Back-to-back: second start in the done cycle of the first.
    issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1,
          32'd0, 32'd0, 32'd0, 8'd0, 32'h0007, exp_st_m);
    wait_done(1);
    issue(4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1,
          32'd0, 32'd0, 32'd0, 8'd0, 32'h00C3, exp_st_m);
    wait_done(1);
    step();

    // Reset during EXEC of add R1+R2 -> R3 with setflags.
    drive(4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0,
          32'd0, 32'd0, 32'd0, 8'd0);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_dout_m = '0;
    exp_st_m   = '0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_status", 32'(status), 32'd0);
    check("abort_dout", 32'(dout), 32'd0);
    extra = 0;
    repeat (8) begin
      step();
      @(negedge clk);
      if (done) extra++;
    end
    check("no_done_after_reset", 32'(extra), 32'd0);
    step();
    for (int r = 0; r < 8; r++) read_reg(4'(r), 32'd0);

    // Parameter sweep: PC into the top register of the narrow/wide instances.
    rna_b = 4'd0; rnb_b = 4'd0; wn_b = 4'hF; wb_b = 1'b1; sf_b = 1'b0;
    op_b = 2'b00; sh_b = 2'b00; vs_b = 2'b11; asel_b = 1'b0; bsel_b = 1'b0;
    pc_b = 8'hA5;
    start8 = 1'b1;
    start32 = 1'b1;
    step();
    scramble();
    @(negedge clk);
    check("sweep8_busy", 32'(busy8), 32'd1);
    check("sweep32_busy", 32'(busy32), 32'd1);
    step();
    @(negedge clk);
    check("sweep8_wdone", 32'(done8), 32'd1);
    check("sweep32_wdone", 32'(done32), 32'd1);
    step();
    rna_b = 4'hF; rnb_b = 4'd0; wn_b = 4'd0; wb_b = 1'b0; sf_b = 1'b0;
    op_b = 2'b00; sh_b = 2'b00; vs_b = 2'b00; asel_b = 1'b0; bsel_b = 1'b1;
    s5_b = 32'd0;
    start8 = 1'b1;
    start32 = 1'b1;
    step();
    scramble();
    repeat (3) step();
    @(negedge clk);
    check("sweep8_early_done", 32'(done8), 32'd0);
    step();
    @(negedge clk);
    check("sweep8_rdone", 32'(done8), 32'd1);
    check("sweep32_rdone", 32'(done32), 32'd1);
    check("sweep8_pc", 32'(dout8), 32'h0000_0005);
    check("sweep32_pc", dout32, 32'h0000_00A5);
    check("sweep8_status", 32'(status8), 32'd0);
    check("sweep32_status", 32'(status32), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
